// File: rtl/mac_accum.sv
// Windowed multiply-accumulate: TAPS signed pixel*coefficient products are summed into one
// wrapping NUM_WIDTH result, with a two-stage (multiply, accumulate) pipeline and a valid/ready result port.
module mac_accum #(
  parameter int IMG_WIDTH  = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_WIDTH  = 33,
  parameter int TAPS       = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         cfg_wr,
  input  logic [7:0]                   cfg_addr,
  input  logic signed [COEF_WIDTH-1:0] cfg_data,
  input  logic signed [IMG_WIDTH-1:0]  up_data,
  input  logic                         up_valid,
  output logic                         up_ready,
  output logic signed [NUM_WIDTH-1:0]  dn_data,
  output logic                         dn_valid,
  input  logic                         dn_ready
);

  localparam int PW = IMG_WIDTH + COEF_WIDTH;
  localparam int CW = $clog2(TAPS);
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    HOLD
  } state_e;

  state_e                       state_q;
  logic [CW-1:0]                tap_q;
  logic                         flush_q;
  logic signed [PW-1:0]         prod_q;
  logic                         prod_vld_q;
  logic                         prod_first_q;
  logic signed [NUM_WIDTH-1:0]  acc_q;
  logic signed [NUM_WIDTH-1:0]  dn_data_q;
  logic                         dn_valid_q;
  logic                         up_ready_q;

  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];

  logic                         cfg_we;
  logic                         take;
  logic signed [PW-1:0]         up_ext;
  logic signed [PW-1:0]         coef_ext;
  logic signed [PW-1:0]         prod_d;
  logic signed [NUM_WIDTH-1:0]  prod_ext;

  assign cfg_we = cfg_wr && (state_q == IDLE) && ({1'b0, cfg_addr} < 9'(TAPS));

  // NOTE: coefficient storage has no reset; it is configuration that must survive rst_n and needs no defined power-up value.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      coef_q[cfg_addr[CW-1:0]] <= cfg_data;
    end
  end

  // A sample is consumed only while running; dropping enable in ACCUM wins over a pending transfer.
  assign take     = (state_q == ACCUM) && enable && up_valid && up_ready_q;
  assign up_ext   = PW'(up_data);
  assign coef_ext = PW'(coef_q[tap_q]);
  assign prod_d   = up_ext * coef_ext;
  assign prod_ext = NUM_WIDTH'(prod_q);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values
  // and a later assignment in the same block cleanly overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tap_q        <= '0;
      flush_q      <= 1'b0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      acc_q        <= '0;
      dn_data_q    <= '0;
      dn_valid_q   <= 1'b0;
      up_ready_q   <= 1'b0;
    end else begin
      prod_vld_q   <= take;
      prod_first_q <= (tap_q == '0);
      if (take) begin
        prod_q <= prod_d;
      end

      if (prod_vld_q) begin
        acc_q <= prod_first_q ? prod_ext : acc_q + prod_ext;
      end

      unique case (state_q)
        IDLE: begin
          up_ready_q <= 1'b0;
          dn_valid_q <= 1'b0;
          tap_q      <= '0;
          if (enable) begin
            state_q    <= ACCUM;
            up_ready_q <= 1'b1;
          end
        end

        ACCUM: begin
          if (!enable) begin
            state_q    <= IDLE;
            up_ready_q <= 1'b0;
            tap_q      <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
          end else if (take) begin
            if (tap_q == LAST_TAP) begin
              state_q    <= FLUSH;
              tap_q      <= '0;
              up_ready_q <= 1'b0;
              flush_q    <= 1'b0;
            end else begin
              tap_q <= tap_q + CW'(1);
            end
          end
        end

        // First FLUSH cycle lets the last product reach the accumulator; the second publishes it.
        FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            state_q    <= HOLD;
            dn_data_q  <= acc_q;
            dn_valid_q <= 1'b1;
          end
        end

        HOLD: begin
          if (dn_ready) begin
            dn_valid_q <= 1'b0;
            state_q    <= enable ? ACCUM : IDLE;
            up_ready_q <= enable;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign up_ready = up_ready_q;
  assign dn_data  = dn_data_q;
  assign dn_valid = dn_valid_q;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: directed and randomized windows compared against a plain-arithmetic
// dot-product model of the coefficient table and the samples sent.
module tb_mac_accum;

  localparam int TAPS = 9;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] up_data;
  logic        up_valid;
  logic        up_ready;
  logic [32:0] dn_data;
  logic        dn_valid;
  logic        dn_ready;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] model_coef [TAPS];
  logic signed [15:0] win_data   [TAPS];

  mac_accum #(
    .IMG_WIDTH (16),
    .COEF_WIDTH(16),
    .NUM_WIDTH (33),
    .TAPS      (TAPS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .cfg_wr  (cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .up_data (up_data),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .dn_data (dn_data),
    .dn_valid(dn_valid),
    .dn_ready(dn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Dot product of the coefficient table and the window, reduced modulo 2^33.
  function automatic logic [32:0] model_sum();
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      s += longint'(model_coef[k]) * longint'(win_data[k]);
    end
    return s[32:0];
  endfunction

  // Only used while the block idles, so an in-range address always lands.
  task automatic cfg_write(input int addr, input logic [15:0] data);
    @(negedge clk);
    cfg_wr   = 1'b1;
    cfg_addr = addr[7:0];
    cfg_data = data;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (addr < TAPS) model_coef[addr] = data;
  endtask

  task automatic load_const(input logic [15:0] val);
    for (int i = 0; i < TAPS; i++) cfg_write(i, val);
  endtask

  task automatic load_random();
    for (int i = 0; i < TAPS; i++) cfg_write(i, 16'($urandom));
  endtask

  task automatic fill_const(input logic [15:0] val);
    for (int i = 0; i < TAPS; i++) win_data[i] = val;
  endtask

  task automatic fill_random();
    for (int i = 0; i < TAPS; i++) win_data[i] = 16'($urandom);
  endtask

  task automatic go_idle();
    enable   = 1'b0;
    up_valid = 1'b0;
    dn_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_up_ready", up_ready, 1'b0);
    check("idle_dn_valid", dn_valid, 1'b0);
  endtask

  // Offers win_data[0..n-1]; returns after the negedge that sets up the n-th accepted transfer.
  task automatic send_taps(input int n, input bit gaps, input bit noise);
    int k;
    int guard;
    k     = 0;
    guard = 0;
    enable = 1'b1;
    while (k < n && guard < 400) begin
      @(negedge clk);
      guard++;
      cfg_wr = 1'b0;
      if (noise && up_ready === 1'b1) begin
        cfg_wr   = 1'b1;
        cfg_addr = 8'($urandom_range(0, TAPS - 1));
        cfg_data = 16'($urandom);
      end
      up_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      up_data  = win_data[k];
      if (up_valid && up_ready === 1'b1) k++;
    end
    check("taps_accepted", k, n);
  endtask

  // dn_valid is registered on the 2nd edge after the last transfer and is therefore
  // first seen by a posedge consumer on the 3rd edge (sampled here at the 3rd negedge).
  task automatic run_window(input string tag, input bit gaps, input bit noise,
                            input int hold, input logic [32:0] exp);
    dn_ready = (hold == 0);
    send_taps(TAPS, gaps, noise);
    @(negedge clk);
    up_valid = 1'b0;
    cfg_wr   = 1'b0;
    check({tag, "_up_ready_drop"}, up_ready, 1'b0);
    check({tag, "_valid_e1"}, dn_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid_e2"}, dn_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid_e3"}, dn_valid, 1'b1);
    check({tag, "_data"}, dn_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, dn_valid, 1'b1);
      check({tag, "_hold_data"}, dn_data, exp);
      check({tag, "_hold_up_ready"}, up_ready, 1'b0);
    end
    dn_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, dn_valid, 1'b0);
    check({tag, "_rearm"}, up_ready, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    up_data  = '0;
    up_valid = 1'b0;
    dn_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_up_ready", up_ready, 1'b0);
    check("rst_dn_valid", dn_valid, 1'b0);
    check("rst_dn_data", dn_data, 33'd0);
    rst_n = 1'b1;

    // Unit coefficients, ramp 1..9; the out-of-range write must not disturb anything.
    load_const(16'd1);
    cfg_write(9, 16'h1234);
    for (int i = 0; i < TAPS; i++) win_data[i] = 16'(i + 1);
    run_window("ramp", 1'b0, 1'b0, 0, 33'd45);
    fill_random();
    run_window("b2b", 1'b0, 1'b0, 0, model_sum());

    go_idle();
    load_const(16'hFFFF);
    fill_const(16'd100);
    run_window("neg", 1'b0, 1'b0, 0, 33'h1FFFFFC7C);

    go_idle();
    load_const(16'h7FFF);
    fill_const(16'h7FFF);
    run_window("wrap", 1'b0, 1'b0, 0, 33'h03FF70009);

    // Long HOLD back-pressure, then a gapped window must start again at tap 0.
    go_idle();
    load_random();
    fill_random();
    run_window("stall", 1'b0, 1'b0, 10, model_sum());
    fill_random();
    run_window("after_stall", 1'b1, 1'b0, 0, model_sum());

    // Configuration writes while running and out-of-range writes while idle are ignored.
    fill_random();
    run_window("cfg_noise", 1'b1, 1'b1, 0, model_sum());
    go_idle();
    cfg_write(9, 16'hAAAA);
    cfg_write(200, 16'h5555);
    fill_random();
    run_window("cfg_range", 1'b0, 1'b0, 0, model_sum());

    // Abort part-way through a window.
    fill_random();
    send_taps(3, 1'b0, 1'b0);
    @(negedge clk);
    enable   = 1'b0;
    up_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_up_ready", up_ready, 1'b0);
    check("abort_dn_valid", dn_valid, 1'b0);
    fill_random();
    run_window("post_abort", 1'b0, 1'b0, 0, model_sum());

    // Reset after four taps; coefficients survive, partial sum does not.
    go_idle();
    load_const(16'd1);
    fill_const(16'd7);
    send_taps(4, 1'b0, 1'b0);
    @(negedge clk);
    up_valid = 1'b0;
    enable   = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_up_ready", up_ready, 1'b0);
    check("midrst_dn_valid", dn_valid, 1'b0);
    check("midrst_dn_data", dn_data, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_waits_idle", up_ready, 1'b0);
    fill_const(16'd2);
    run_window("after_reset", 1'b0, 1'b0, 0, 33'd18);

    for (int r = 0; r < 6; r++) begin
      go_idle();
      load_random();
      fill_random();
      run_window("rand", 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 3)), model_sum());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
